// File: rtl/givens_sched_pkg.sv
// Shared types and constants for the 4x4 Givens QR rotation sequencer.
package givens_pkg;

    localparam int          N           = 4;
    localparam logic [31:0] FP_ABS_MASK = 32'h7FFF_FFFF;

    typedef logic [31:0]         fp32_t;
    typedef fp32_t [0:3][0:3]    mat4_t;
    typedef logic [1:0]          idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_UPD,
        DONE
    } sched_state_t;

endpackage

// File: rtl/givens_sched_if.sv
// Rotation-operand handshake between the sequencer and the c/s generator.
interface givens_sched_if;
    import givens_pkg::*;

    logic  op_valid;
    logic  op_ready;
    fp32_t op_a;
    fp32_t op_b;
    idx_t  op_i;
    idx_t  op_j;
    idx_t  op_col;

    modport master (
        output op_valid, op_a, op_b, op_i, op_j, op_col,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_a, op_b, op_i, op_j, op_col,
        output op_ready
    );

endinterface

// File: rtl/givens_pos_cnt.sv
// Column/row walker over the sub-diagonal elimination order, bottom row first.
module givens_pos_cnt
    import givens_pkg::*;
#(
    parameter int N_DIM = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic init,
    input  logic advance,
    output idx_t col,
    output idx_t row,
    output logic is_last
);

    localparam idx_t LAST_ROW = idx_t'(N_DIM - 1);
    localparam idx_t LAST_COL = idx_t'(N_DIM - 2);

    idx_t col_q, col_d;
    idx_t row_q, row_d;

    // Move up the column until just below the diagonal, then restart at the bottom of the next one.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (init) begin
            col_d = '0;
            row_d = LAST_ROW;
        end else if (advance) begin
            if (row_q > col_q + 2'd1) begin
                row_d = row_q - 2'd1;
            end else begin
                col_d = col_q + 2'd1;
                row_d = LAST_ROW;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= LAST_ROW;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col     = col_q;
    assign row     = row_q;
    assign is_last = (col_q == LAST_COL) && (row_q == LAST_ROW);

endmodule

// File: rtl/givens_sched.sv
// Sequencer for 4x4 Givens QR: issues (a, b, i, j, col) per sub-diagonal element
// and waits for the updated R after each rotation; zero targets are skipped.
module givens_sched
    import givens_pkg::*;
#(
    parameter int N         = 4,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  mat4_t          r_in,
    input  logic           upd_valid,
    givens_sched_if.master op,
    output logic           busy,
    output logic           done,
    output logic [2:0]     rot_count
);

    sched_state_t state_q, state_d;
    mat4_t        r_q, r_d;
    logic [2:0]   rot_count_q, rot_count_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    idx_t  col, row;
    logic  pos_last, pos_init, pos_advance;
    fp32_t a_val, b_val;
    logic  skip, issue_valid;

    givens_pos_cnt #(.N_DIM(N)) u_pos (
        .clock   (clock),
        .reset   (reset),
        .init    (pos_init),
        .advance (pos_advance),
        .col     (col),
        .row     (row),
        .is_last (pos_last)
    );

    // The sign bit is masked so -0.0 also counts as an already-cleared element.
    always_comb begin
        a_val       = r_q[row - 2'd1][col];
        b_val       = r_q[row][col];
        skip        = SKIP_ZERO && ((b_val & FP_ABS_MASK) == 32'h0);
        issue_valid = (state_q == ISSUE) && !skip;
    end

    // Operands are driven straight from R and the counters, so they cannot move while stalled.
    assign op.op_valid = issue_valid;
    assign op.op_a     = issue_valid ? a_val : '0;
    assign op.op_b     = issue_valid ? b_val : '0;
    assign op.op_i     = issue_valid ? row - 2'd1 : '0;
    assign op.op_j     = issue_valid ? row : '0;
    assign op.op_col   = issue_valid ? col : '0;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        rot_count_d = rot_count_q;
        pos_init    = 1'b0;
        pos_advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    r_d         = r_in;
                    pos_init    = 1'b1;
                    rot_count_d = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (skip) begin
                    pos_advance = !pos_last;
                    state_d     = pos_last ? DONE : ISSUE;
                end else if (op.op_ready) begin
                    rot_count_d = rot_count_q + 3'd1;
                    state_d     = WAIT_UPD;
                end
            end
            WAIT_UPD: begin
                if (upd_valid) begin
                    r_d         = r_in;
                    pos_advance = !pos_last;
                    state_d     = pos_last ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            rot_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            rot_count_q <= rot_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rot_count = rot_count_q;

endmodule

// File: tb/tb_givens_sched.sv
// Scoreboard bench for givens_sched: expected operand tuples are queued when a run
// starts and popped by a monitor on every op transfer.
module tb_givens_sched;
    import givens_pkg::*;

    typedef struct packed {
        idx_t  i;
        idx_t  j;
        idx_t  col;
        fp32_t a;
        fp32_t b;
    } op_t;

    logic       clock;
    logic       reset;
    logic       start;
    mat4_t      r_in;
    logic       upd_valid;
    logic       busy;
    logic       done;
    logic [2:0] rot_count;

    givens_sched_if op_if ();

    givens_sched #(.N(4), .SKIP_ZERO(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .r_in      (r_in),
        .upd_valid (upd_valid),
        .op        (op_if),
        .busy      (busy),
        .done      (done),
        .rot_count (rot_count)
    );

    int  checks = 0;
    int  errors = 0;
    op_t exp_q[$];
    op_t mon_e;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent model: fixed position table, skip when |b| is zero.
    function automatic int build_expected(input mat4_t m);
        int pc[6] = '{0, 0, 0, 1, 1, 2};
        int pr[6] = '{3, 2, 1, 3, 2, 3};
        int n = 0;
        op_t e;
        for (int k = 0; k < 6; k++) begin
            if ((m[pr[k]][pc[k]] & 32'h7FFF_FFFF) != 32'h0) begin
                e.i   = idx_t'(pr[k] - 1);
                e.j   = idx_t'(pr[k]);
                e.col = idx_t'(pc[k]);
                e.a   = m[pr[k] - 1][pc[k]];
                e.b   = m[pr[k]][pc[k]];
                exp_q.push_back(e);
                n++;
            end
        end
        return n;
    endfunction

    always @(negedge clock) begin
        if (!reset && op_if.op_valid && op_if.op_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_op: got i=%0d j=%0d col=%0d b=%h, required no op",
                         op_if.op_i, op_if.op_j, op_if.op_col, op_if.op_b);
            end else begin
                mon_e = exp_q.pop_front();
                if ({op_if.op_i, op_if.op_j, op_if.op_col, op_if.op_a, op_if.op_b} !== mon_e) begin
                    errors++;
                    $display("[TB] FAIL op_transfer: got i=%0d j=%0d col=%0d a=%h b=%h, required i=%0d j=%0d col=%0d a=%h b=%h",
                             op_if.op_i, op_if.op_j, op_if.op_col, op_if.op_a, op_if.op_b,
                             mon_e.i, mon_e.j, mon_e.col, mon_e.a, mon_e.b);
                end
            end
        end
    end

    task automatic applyStart(input mat4_t m);
        r_in  = m;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Answers each transfer with an update two cycles later; optionally stops after max_xfers.
    task automatic run_ops(input int budget, input int max_xfers, input bit start_with_upd,
                           output int cycles, output int valid_cycles, output bit saw_done);
        int xfers = 0;
        cycles = 0;
        valid_cycles = 0;
        saw_done = 1'b0;
        while (!saw_done && cycles < budget && (max_xfers == 0 || xfers < max_xfers)) begin
            @(negedge clock);
            cycles++;
            if (op_if.op_valid) valid_cycles++;
            if (done) begin
                saw_done = 1'b1;
            end else if (op_if.op_valid && op_if.op_ready) begin
                xfers++;
                @(posedge clock); #1;
                if (max_xfers == 0 || xfers < max_xfers) begin
                    @(posedge clock); #1;
                    upd_valid = 1'b1;
                    if (start_with_upd) start = 1'b1;
                    @(posedge clock); #1;
                    upd_valid = 1'b0;
                    start = 1'b0;
                    cycles += 2;
                end
            end
        end
        checks++;
        if (!(saw_done || (max_xfers != 0 && xfers == max_xfers))) begin
            errors++;
            $display("[TB] FAIL run_timeout: got %0d transfers and done=%0d after %0d cycles, required completion",
                     xfers, saw_done, cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({op_if.op_valid, busy, done, rot_count} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got valid=%0d busy=%0d done=%0d rot=%0d, required all 0",
                     op_if.op_valid, busy, done, rot_count);
        end
        checks++;
        if ({op_if.op_a, op_if.op_b, op_if.op_i, op_if.op_j, op_if.op_col} !== 70'b0) begin
            errors++;
            $display("[TB] FAIL reset_ops: got a=%h b=%h i=%0d j=%0d col=%0d, required all 0",
                     op_if.op_a, op_if.op_b, op_if.op_i, op_if.op_j, op_if.op_col);
        end
    endtask

    task automatic test_dense();
        mat4_t m;
        int n, cyc, vc;
        bit sd;
        @(posedge clock); #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 32'h3F80_0000;
        n = build_expected(m);
        op_if.op_ready = 1'b1;
        applyStart(m);
        run_ops(300, 0, 1'b0, cyc, vc, sd);
        checks++;
        if (rot_count !== 3'd6 || n != 6) begin
            errors++;
            $display("[TB] FAIL dense_rot_count: got %0d, required 6", rot_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL dense_ops_left: got %0d pending, required 0", exp_q.size());
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dense_done_pulse: got done=%0d busy=%0d, required 0 0", done, busy);
        end
    endtask

    task automatic test_upper_tri();
        mat4_t m;
        int n, cyc, vc;
        bit sd;
        @(posedge clock); #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = (r > c) ? ((r == 2) ? 32'h8000_0000 : 32'h0) : 32'h3F80_0000;
        n = build_expected(m);
        op_if.op_ready = 1'b1;
        applyStart(m);
        run_ops(300, 0, 1'b0, cyc, vc, sd);
        checks++;
        if (vc != 0 || n != 0) begin
            errors++;
            $display("[TB] FAIL tri_no_valid: got %0d valid cycles, required 0", vc);
        end
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("[TB] FAIL tri_done_latency: got %0d cycles, required 8", cyc);
        end
        checks++;
        if (rot_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL tri_rot_count: got %0d, required 0", rot_count);
        end
    endtask

    task automatic test_neg_zero_skip();
        mat4_t m;
        int n, cyc, vc;
        bit sd;
        @(posedge clock); #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = (r > c) ? 32'h4000_0000 : 32'h3F80_0000 + 32'(r * 4 + c);
        m[3][0] = 32'h8000_0000;
        n = build_expected(m);
        op_if.op_ready = 1'b0;
        applyStart(m);
        @(negedge clock);
        checks++;
        if (op_if.op_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL negzero_skip_cycle: got valid=%0d, required 0", op_if.op_valid);
        end
        @(negedge clock);
        checks++;
        if (op_if.op_valid !== 1'b1 || op_if.op_i !== 2'd1 || op_if.op_j !== 2'd2 || op_if.op_b !== 32'h4000_0000) begin
            errors++;
            $display("[TB] FAIL negzero_first_op: got valid=%0d i=%0d j=%0d b=%h, required 1 1 2 40000000",
                     op_if.op_valid, op_if.op_i, op_if.op_j, op_if.op_b);
        end
        @(posedge clock); #1;
        op_if.op_ready = 1'b1;
        run_ops(300, 0, 1'b0, cyc, vc, sd);
        checks++;
        if (rot_count !== 3'd5 || n != 5) begin
            errors++;
            $display("[TB] FAIL negzero_rot_count: got %0d, required 5", rot_count);
        end
    endtask

    task automatic test_backpressure();
        mat4_t m;
        op_t first;
        int n, cyc, vc;
        bit sd;
        @(posedge clock); #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 32'h4100_0000 + 32'(r * 4 + c);
        n = build_expected(m);
        first = exp_q[0];
        op_if.op_ready = 1'b0;
        applyStart(m);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if (op_if.op_valid !== 1'b1 ||
                {op_if.op_i, op_if.op_j, op_if.op_col, op_if.op_a, op_if.op_b} !== first) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got valid=%0d i=%0d j=%0d a=%h b=%h, required 1 %0d %0d %h %h",
                         k, op_if.op_valid, op_if.op_i, op_if.op_j, op_if.op_a, op_if.op_b,
                         first.i, first.j, first.a, first.b);
            end
        end
        checks++;
        if (rot_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL stall_no_xfer: got rot=%0d, required 0", rot_count);
        end
        @(posedge clock); #1;
        op_if.op_ready = 1'b1;
        run_ops(300, 0, 1'b0, cyc, vc, sd);
        checks++;
        if (rot_count !== 3'(n)) begin
            errors++;
            $display("[TB] FAIL stall_rot_count: got %0d, required %0d", rot_count, n);
        end
    endtask

    task automatic test_spurious();
        mat4_t m, junk;
        op_t first;
        int n, cyc, vc;
        bit sd;
        @(posedge clock); #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                m[r][c]    = 32'h3F00_0000 + 32'(r * 16 + c);
                junk[r][c] = 32'h1234_5678;
            end
        m[1][0] = 32'h7F80_0000;
        m[2][1] = 32'h7FC0_0000;
        m[3][2] = 32'h0000_0001;
        m[2][0] = 32'h8000_0000;
        n = build_expected(m);
        first = exp_q[0];
        op_if.op_ready = 1'b0;
        applyStart(m);
        r_in      = junk;
        upd_valid = 1'b1;
        start     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        upd_valid = 1'b0;
        start     = 1'b0;
        r_in      = m;
        @(negedge clock);
        checks++;
        if ({op_if.op_i, op_if.op_j, op_if.op_col, op_if.op_a, op_if.op_b} !== first || rot_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL spurious_r_kept: got i=%0d j=%0d a=%h b=%h rot=%0d, required %0d %0d %h %h 0",
                     op_if.op_i, op_if.op_j, op_if.op_a, op_if.op_b, rot_count,
                     first.i, first.j, first.a, first.b);
        end
        @(posedge clock); #1;
        op_if.op_ready = 1'b1;
        run_ops(300, 0, 1'b1, cyc, vc, sd);
        checks++;
        if (rot_count !== 3'(n) || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL spurious_rot_count: got %0d (pending %0d), required %0d (pending 0)",
                     rot_count, exp_q.size(), n);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || op_if.op_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_no_restart: got busy=%0d valid=%0d, required 0 0", busy, op_if.op_valid);
        end
    endtask

    task automatic test_reset_mid();
        mat4_t m;
        int n, cyc, vc;
        bit sd;
        int done_seen = 0;
        @(posedge clock); #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 32'hBF80_0000 - 32'(r * 4 + c);
        n = build_expected(m);
        op_if.op_ready = 1'b1;
        applyStart(m);
        run_ops(300, 3, 1'b0, cyc, vc, sd);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || op_if.op_valid !== 1'b0 || rot_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got busy=%0d valid=%0d rot=%0d, required 0 0 0",
                     busy, op_if.op_valid, rot_count);
        end
        if (done) done_seen++;
        repeat (4) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d done cycles, required 0", done_seen);
        end
        @(posedge clock); #1;
        n = build_expected(m);
        applyStart(m);
        run_ops(300, 0, 1'b0, cyc, vc, sd);
        checks++;
        if (rot_count !== 3'(n) || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_rerun: got rot=%0d pending=%0d, required %0d 0",
                     rot_count, exp_q.size(), n);
        end
    endtask

    initial begin
        start          = 1'b0;
        upd_valid      = 1'b0;
        r_in           = '0;
        op_if.op_ready = 1'b0;
        test_reset();
        test_dense();
        test_upper_tri();
        test_neg_zero_skip();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
